// File: rtl/sel_sequencer_if.sv
// Control/select bundle between the sequencer and whatever drives it.
// The driver (master) issues commands; the sequencer (slave) returns the select index and status pulses.
interface sel_sequencer_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic [1:0]         mode;
    logic [2:0]         load_val;
    logic [DWELL_W-1:0] dwell;
    logic [2:0]         sel;
    logic               sel_valid;
    logic               step;
    logic               done;

    modport master (
        output start, stop, mode, load_val, dwell,
        input  sel, sel_valid, step, done
    );

    modport slave (
        input  start, stop, mode, load_val, dwell,
        output sel, sel_valid, step, done
    );
endinterface

// File: rtl/sel_sequencer.sv
// Select-index sequencer for a 3-to-8 decoder: up/down scan, single 0..7 sweep or direct load,
// with each index held for a programmable dwell.
module sel_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    sel_sequencer_if.slave bus
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [1:0] MODE_UP    = 2'b00;
    localparam logic [1:0] MODE_DOWN  = 2'b01;
    localparam logic [1:0] MODE_SWEEP = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    state_t             state_q;
    logic [2:0]         sel_q;
    logic [1:0]         mode_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] cnt_q;
    logic               step_q;
    logic               done_q;
    logic [DWELL_W-1:0] dwell_eff_d;

    // A programmed dwell of zero still holds each index for one cycle.
    assign dwell_eff_d = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            mode_q  <= MODE_UP;
            dwell_q <= DWELL_W'(1);
            cnt_q   <= '0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            step_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.mode == MODE_LOAD) begin
                            sel_q <= bus.load_val;
                        end else begin
                            mode_q  <= bus.mode;
                            dwell_q <= dwell_eff_d;
                            cnt_q   <= dwell_eff_d - DWELL_W'(1);
                            if (bus.mode == MODE_SWEEP) begin
                                sel_q <= 3'd0;
                            end
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    // Abort takes priority over any advance or completion due this cycle.
                    if (bus.stop) begin
                        state_q <= IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - DWELL_W'(1);
                    end else if (mode_q == MODE_SWEEP && sel_q == 3'd7) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        sel_q  <= (mode_q == MODE_DOWN) ? sel_q - 3'd1 : sel_q + 3'd1;
                        cnt_q  <= dwell_q - DWELL_W'(1);
                        step_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.sel       = sel_q;
    assign bus.sel_valid = (state_q == RUN);
    assign bus.step      = step_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_sel_sequencer.sv
// Directed bench for sel_sequencer: reset, sweep, down-scan wrap, zero dwell, stop and mid-run reset.
module tb_sel_sequencer;

    localparam int DWELL_W = 8;

    logic clk;
    logic rst;
    int   chk_cnt;
    int   pass_cnt;
    int   step_cnt;

    sel_sequencer_if #(.DWELL_W(DWELL_W)) bus ();

    sel_sequencer #(.DWELL_W(DWELL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int s, input int v, input int st, input int d);
        chk({tag, ".sel"},   32'(bus.sel),       32'(s));
        chk({tag, ".valid"}, 32'(bus.sel_valid), 32'(v));
        chk({tag, ".step"},  32'(bus.step),      32'(st));
        chk({tag, ".done"},  32'(bus.done),      32'(d));
    endtask

    task automatic load(input logic [2:0] v);
        bus.mode = 2'b11; bus.load_val = v; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        chk_cnt = 0; pass_cnt = 0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 2'b00;
        bus.load_val = 3'd0; bus.dwell = 8'd1;
        rst = 1'b1;
        #1;

        // T1 reset
        tick(); tick();
        chk_out("t1", 0, 0, 0, 0);
        rst = 1'b0;

        // T2 single sweep, dwell 3
        bus.mode = 2'b10; bus.dwell = 8'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        step_cnt = 0;
        for (int c = 0; c < 24; c++) begin
            chk_out($sformatf("t2.c%0d", c), c / 3, 1, (c > 0 && c % 3 == 0) ? 1 : 0, 0);
            if (bus.step) step_cnt++;
            tick();
        end
        chk_out("t2.end", 7, 0, 0, 1);
        chk("t2.steps", 32'(step_cnt), 32'd7);
        tick();
        chk_out("t2.after", 7, 0, 0, 0);

        // T3 load 1 then scan down with wrap
        load(3'd1);
        chk_out("t3.load", 1, 0, 0, 0);
        bus.mode = 2'b01; bus.dwell = 8'd1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk_out("t3.s0", 1, 1, 0, 0);
        tick(); chk_out("t3.s1", 0, 1, 1, 0);
        tick(); chk_out("t3.s2", 7, 1, 1, 0);
        tick(); chk_out("t3.s3", 6, 1, 1, 0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk_out("t3.stop", 6, 0, 0, 0);

        // T4 dwell 0 behaves as 1
        load(3'd6);
        bus.mode = 2'b00; bus.dwell = 8'd0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk_out("t4.s0", 6, 1, 0, 0);
        tick(); chk_out("t4.s1", 7, 1, 1, 0);
        tick(); chk_out("t4.s2", 0, 1, 1, 0);
        tick(); chk_out("t4.s3", 1, 1, 1, 0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk_out("t4.stop", 1, 0, 0, 0);

        // T5 stop lands on the cycle an advance was due
        load(3'd3);
        bus.mode = 2'b00; bus.dwell = 8'd2; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk_out("t5.s0", 3, 1, 0, 0);
        tick();
        chk_out("t5.s0b", 3, 1, 0, 0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk_out("t5.stop", 3, 0, 0, 0);
        tick();
        chk_out("t5.idle", 3, 0, 0, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk_out("t5.r0", 3, 1, 0, 0);
        tick(); chk_out("t5.r1", 3, 1, 0, 0);
        tick(); chk_out("t5.r2", 4, 1, 1, 0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;

        // T6 start/mode changes ignored in RUN, then reset mid-sweep
        bus.mode = 2'b10; bus.dwell = 8'd1; bus.start = 1'b1;
        tick();
        chk_out("t6.s0", 0, 1, 0, 0);
        bus.mode = 2'b01; bus.dwell = 8'd5; bus.load_val = 3'd5;
        tick(); chk_out("t6.s1", 1, 1, 1, 0);
        bus.mode = 2'b11;
        tick(); chk_out("t6.s2", 2, 1, 1, 0);
        tick(); chk_out("t6.s3", 3, 1, 1, 0);
        tick(); chk_out("t6.s4", 4, 1, 1, 0);
        bus.start = 1'b0;
        rst = 1'b1;
        tick();
        chk_out("t6.rst", 0, 0, 0, 0);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk_out($sformatf("t6.post%0d", c), 0, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
